byte_serial_adder: RTL and testbench

// Multi-byte adder sequencer wrapped around the existing 8-bit adder (a, b -> sum, c_out; no carry-in).

---
 rtl/byte_serial_adder_if.sv | 37 +++
 rtl/byte_serial_adder.sv | 127 ++++++++++++
 tb/tb_byte_serial_adder.sv | 172 +++++++++++++++++
 3 files changed

// File: rtl/byte_serial_adder_if.sv
// byte_serial_adder_if
//   Bundles the operand request, the external 8-bit adder hookup and the
//   result hand-off of byte_serial_adder.
//   op_valid/op_ready/op_a/op_b/op_cin : operand request (W = 8*NBYTES)
//   add_a/add_b -> add_sum/add_cout    : external 8-bit adder, no carry-in
//   res_valid/res_ready/res_sum/res_cout : registered wide result
//   slave  modport : the sequencer side
//   master modport : the requester / adder side
interface byte_serial_adder_if #(
    parameter int NBYTES = 4
) ();
    localparam int W = 8 * NBYTES;

    logic         op_valid;
    logic         op_ready;
    logic [W-1:0] op_a;
    logic [W-1:0] op_b;
    logic         op_cin;
    logic [7:0]   add_a;
    logic [7:0]   add_b;
    logic [7:0]   add_sum;
    logic         add_cout;
    logic         res_valid;
    logic         res_ready;
    logic [W-1:0] res_sum;
    logic         res_cout;

    modport slave (
        input  op_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
        output op_ready, add_a, add_b, res_valid, res_sum, res_cout
    );

    modport master (
        output op_valid, op_a, op_b, op_cin, add_sum, add_cout, res_ready,
        input  op_ready, add_a, add_b, res_valid, res_sum, res_cout
    );
endinterface

// File: rtl/byte_serial_adder.sv
// byte_serial_adder
//   Multi-byte adder sequencer around an external 8-bit adder that has no
//   carry-in. Each byte takes two passes through the adder: A+B first, then
//   the partial sum plus the running carry. The two carries can never both
//   be set, so OR-ing them gives the byte's carry-out. Latency is fixed at
//   2*NBYTES cycles from accept to res_valid.
//   Ports:
//     clk   : rising-edge clock
//     rst_n : asynchronous active-low reset (aborts any operation)
//     bus   : byte_serial_adder_if.slave (operand, adder and result signals)
module byte_serial_adder #(
    parameter int NBYTES = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    byte_serial_adder_if.slave   bus
);
    localparam int IDXW = (NBYTES > 1) ? $clog2(NBYTES) : 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        ADD_AB  = 2'd1,
        ADD_CIN = 2'd2,
        DONE    = 2'd3
    } state_t;

    state_t                  state_q, state_d;
    logic [IDXW-1:0]         idx_q, idx_d;
    logic                    carry_q, carry_d;
    logic                    cout_q, cout_d;
    logic [NBYTES-1:0][7:0]  sum_q, sum_d;
    // Operand and inter-pass scratch registers: no reset needed, they are
    // always written before being read.
    logic [NBYTES-1:0][7:0]  a_q, a_d;
    logic [NBYTES-1:0][7:0]  b_q, b_d;
    logic [7:0]              tmp_q, tmp_d;
    logic                    c1_q, c1_d;

    logic [7:0]              add_a_c;
    logic [7:0]              add_b_c;

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        sum_d   = sum_q;
        a_d     = a_q;
        b_d     = b_q;
        tmp_d   = tmp_q;
        c1_d    = c1_q;
        add_a_c = 8'h00;
        add_b_c = 8'h00;

        case (state_q)
            IDLE: begin
                if (bus.op_valid) begin
                    a_d     = bus.op_a;
                    b_d     = bus.op_b;
                    carry_d = bus.op_cin;
                    idx_d   = '0;
                    state_d = ADD_AB;
                end
            end
            ADD_AB: begin
                add_a_c = a_q[idx_q];
                add_b_c = b_q[idx_q];
                tmp_d   = bus.add_sum;
                c1_d    = bus.add_cout;
                state_d = ADD_CIN;
            end
            ADD_CIN: begin
                // Second pass folds the incoming carry into the partial sum.
                add_a_c        = tmp_q;
                add_b_c        = {7'b0, carry_q};
                sum_d[idx_q]   = bus.add_sum;
                carry_d        = c1_q | bus.add_cout;
                if (idx_q == LAST_IDX) begin
                    cout_d  = c1_q | bus.add_cout;
                    state_d = DONE;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = ADD_AB;
                end
            end
            DONE: begin
                if (bus.res_ready) begin
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            sum_q   <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            sum_q   <= sum_d;
        end
    end

    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        tmp_q <= tmp_d;
        c1_q  <= c1_d;
    end

    assign bus.add_a     = add_a_c;
    assign bus.add_b     = add_b_c;
    assign bus.op_ready  = (state_q == IDLE);
    assign bus.res_valid = (state_q == DONE);
    assign bus.res_sum   = sum_q;
    assign bus.res_cout  = cout_q;
endmodule

// File: tb/tb_byte_serial_adder.sv
// tb_byte_serial_adder
//   Directed and random bench for byte_serial_adder with NBYTES=4. An 8-bit
//   adder without carry-in is modelled between add_a/add_b and add_sum/add_cout.
module tb_byte_serial_adder;
    localparam int NBYTES = 4;

    logic clk;
    logic rst_n;
    int   n_chk;
    int   n_err;

    byte_serial_adder_if #(.NBYTES(NBYTES)) bus ();

    byte_serial_adder #(.NBYTES(NBYTES)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    logic [8:0] adder9;
    assign adder9       = {1'b0, bus.add_a} + {1'b0, bus.add_b};
    assign bus.add_sum  = adder9[7:0];
    assign bus.add_cout = adder9[8];

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic start_op(input logic [31:0] a, input logic [31:0] b, input logic cin);
        bus.op_a     = a;
        bus.op_b     = b;
        bus.op_cin   = cin;
        bus.op_valid = 1'b1;
        tick();
        bus.op_valid = 1'b0;
    endtask

    task automatic wait_res(input string tag);
        int lat;
        lat = 0;
        while (!bus.res_valid && lat < 40) begin
            tick();
            lat++;
        end
        check({tag, "_lat"}, 64'(lat), 64'd8);
    endtask

    task automatic release_res();
        bus.res_ready = 1'b1;
        tick();
        bus.res_ready = 1'b0;
    endtask

    task automatic run_op(input string tag, input logic [31:0] a, input logic [31:0] b,
                          input logic cin, input logic [31:0] exp_sum, input logic exp_cout);
        check({tag, "_rdy"}, 64'(bus.op_ready), 64'd1);
        start_op(a, b, cin);
        wait_res(tag);
        check({tag, "_sum"}, 64'(bus.res_sum), 64'(exp_sum));
        check({tag, "_cout"}, 64'(bus.res_cout), 64'(exp_cout));
        release_res();
        check({tag, "_idle"}, 64'(bus.op_ready), 64'd1);
    endtask

    initial begin
        logic [31:0] ra, rb, hold_sum;
        logic        rc, hold_cout;
        logic [32:0] ref_val;

        n_chk = 0;
        n_err = 0;
        bus.op_valid  = 1'b0;
        bus.op_a      = '0;
        bus.op_b      = '0;
        bus.op_cin    = 1'b0;
        bus.res_ready = 1'b0;
        rst_n         = 1'b0;

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_valid", 64'(bus.res_valid), 64'd0);
        check("rst_sum",   64'(bus.res_sum),   64'd0);
        check("rst_cout",  64'(bus.res_cout),  64'd0);
        rst_n = 1'b1;
        tick();
        check("rst_ready", 64'(bus.op_ready), 64'd1);
        check("rst_add_a", 64'(bus.add_a),    64'd0);
        check("rst_add_b", 64'(bus.add_b),    64'd0);

        // Directed vectors
        run_op("zero",  32'h00000000, 32'h00000000, 1'b0, 32'h00000000, 1'b0);
        run_op("ripple", 32'hFFFFFFFF, 32'h00000001, 1'b0, 32'h00000000, 1'b1);
        run_op("mix",   32'h12345678, 32'h87654321, 1'b0, 32'h99999999, 1'b0);
        run_op("cin",   32'h7FFFFFFF, 32'h00000000, 1'b1, 32'h80000000, 1'b0);
        run_op("allff", 32'hFFFFFFFF, 32'hFFFFFFFF, 1'b1, 32'hFFFFFFFF, 1'b1);

        // Backpressure: result held while res_ready=0, op_valid ignored
        start_op(32'h0000FF00, 32'h00000100, 1'b0);
        wait_res("bp");
        hold_sum  = bus.res_sum;
        hold_cout = bus.res_cout;
        check("bp_sum", 64'(hold_sum), 64'h00010000);
        for (int i = 0; i < 5; i++) begin
            bus.op_valid = i[0];
            bus.op_a     = 32'hDEAD0000 + 32'(i);
            bus.op_b     = 32'h0000BEEF;
            tick();
            check("bp_valid_hold", 64'(bus.res_valid), 64'd1);
            check("bp_sum_hold",   64'(bus.res_sum),   64'(hold_sum));
            check("bp_cout_hold",  64'(bus.res_cout),  64'(hold_cout));
            check("bp_ready_low",  64'(bus.op_ready),  64'd0);
            check("bp_add_a_zero", 64'(bus.add_a),     64'd0);
        end
        // Hand-off edge with op_valid still high must not start a new op
        bus.op_valid  = 1'b1;
        bus.res_ready = 1'b1;
        tick();
        bus.op_valid  = 1'b0;
        bus.res_ready = 1'b0;
        check("bp_to_idle",   64'(bus.op_ready),  64'd1);
        check("bp_valid_off", 64'(bus.res_valid), 64'd0);
        check("bp_sum_kept",  64'(bus.res_sum),   64'(hold_sum));
        tick();
        check("bp_no_restart", 64'(bus.op_ready), 64'd1);

        // Reset during ADD_CIN of byte 2
        start_op(32'h11111111, 32'h22222222, 1'b0);
        repeat (5) tick();
        check("mid_add_b_carry", 64'(bus.add_a), 64'h33);
        rst_n = 1'b0;
        #1;
        check("mid_valid", 64'(bus.res_valid), 64'd0);
        check("mid_sum",   64'(bus.res_sum),   64'd0);
        check("mid_cout",  64'(bus.res_cout),  64'd0);
        tick();
        rst_n = 1'b1;
        tick();
        check("mid_ready", 64'(bus.op_ready), 64'd1);
        run_op("post_rst", 32'h00000005, 32'h00000003, 1'b0, 32'h00000008, 1'b0);

        // Random operands against a 33-bit reference
        for (int i = 0; i < 1000; i++) begin
            ra      = $urandom;
            rb      = $urandom;
            rc      = 1'($urandom_range(0, 1));
            ref_val = {1'b0, ra} + {1'b0, rb} + {32'b0, rc};
            run_op("rnd", ra, rb, rc, ref_val[31:0], ref_val[32]);
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end
endmodule
